// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and transmitter-side signals of the shared UART TX arbiter.
// A slot byte moves when req_valid[i] & req_ready[i] on a clock edge; tx_load is a one-cycle pulse.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int BYTE_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*BYTE_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [BYTE_W-1:0]         tx_data;
   logic                      tx_load;
   logic                      tx_load_okay;

   modport slave (
      input  req_valid, req_data, tx_load_okay,
      output req_ready, tx_data, tx_load
   );

   modport master (
      output req_valid, req_data, tx_load_okay,
      input  req_ready, tx_data, tx_load
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ one-byte holding slots.
// Each grant pulses tx_load, then waits for the transmitter to report idle before the next grant.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BYTE_W       = 8,
   parameter int BUSY_TIMEOUT = 16,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int TMR_W       = $clog2(BUSY_TIMEOUT) + 1
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             en,
   uart_tx_arbiter_if.slave bus,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              state;
   logic [NUM_REQ-1:0]  slot_full;
   logic [BYTE_W-1:0]   slot_data [NUM_REQ];
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     pick_id;
   logic                pick_found;
   logic                grant;
   logic [TMR_W-1:0]    timer;
   int                  idx;
   logic [ID_W-1:0]     idx_w;

   // First full slot strictly after the last grant, wrapping, so the last winner ranks lowest.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = 0;
      idx_w      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = ID_W'(idx);
         if (!pick_found && slot_full[idx_w]) begin
            pick_found = 1'b1;
            pick_id    = idx_w;
         end
      end
   end

   assign grant         = (state == S_IDLE) && en && bus.tx_load_okay && pick_found;
   assign bus.req_ready = ~slot_full;
   assign busy          = (state != S_IDLE);
   assign state_dbg     = state;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         slot_full <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (pick_id == ID_W'(i))) begin
               slot_full[i] <= 1'b0;
            end else if (bus.req_valid[i] && !slot_full[i]) begin
               slot_full[i] <= 1'b1;
               slot_data[i] <= bus.req_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= S_IDLE;
         bus.tx_data <= '0;
         bus.tx_load <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= ID_W'(NUM_REQ - 1);
         timer       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  bus.tx_data <= slot_data[pick_id];
                  bus.tx_load <= 1'b1;
                  grant_id    <= pick_id;
                  rr_ptr      <= pick_id;
                  state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               bus.tx_load <= 1'b0;
               timer       <= '0;
               state       <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // A transmitter that never drops tx_load_okay must not hang the scheduler.
               if (!bus.tx_load_okay) begin
                  state <= S_WAIT_DONE;
               end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (bus.tx_load_okay) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy-counter transmitter model.
// Expected (grant_id, byte) pairs are queued at stimulus time and popped on each tx_load.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int BYTE_W       = 8;
   localparam int BUSY_TIMEOUT = 16;
   localparam int ID_W         = 2;
   localparam int TX_BUSY      = 10;

   logic            sys_clk = 1'b0;
   logic            rst;
   logic            en;
   logic [ID_W-1:0] grant_id;
   logic            busy;
   logic [1:0]      state_dbg;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .BYTE_W(BYTE_W)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .BYTE_W(BYTE_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .en        (en),
      .bus       (bus.slave),
      .grant_id  (grant_id),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 sys_clk = ~sys_clk;

   int   checks    = 0;
   int   failures  = 0;
   int   load_cnt  = 0;
   int   busy_cnt  = 0;
   bit   tx_stuck_idle = 1'b0;
   logic prev_load = 1'b0;
   logic [ID_W+BYTE_W-1:0] exp_q[$];
   logic [ID_W+BYTE_W-1:0] mon_e;

   // Transmitter model: goes busy for TX_BUSY cycles after each load unless stuck idle.
   assign bus.tx_load_okay = (busy_cnt == 0);
   always @(posedge sys_clk) begin
      if (bus.tx_load && !tx_stuck_idle) busy_cnt <= TX_BUSY;
      else if (busy_cnt != 0)            busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      if (bus.tx_load === 1'b1) begin
         load_cnt++;
         check("load_pulse_width", 32'(prev_load), 0);
         check("load_while_tx_busy", 32'(bus.tx_load_okay), 1);
         if (exp_q.size() == 0) begin
            check("unexpected_load", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(mon_e[BYTE_W-1:0]));
            check("grant_id", 32'(grant_id), 32'(mon_e[ID_W+BYTE_W-1:BYTE_W]));
         end
      end
      prev_load = bus.tx_load;
   end

   task automatic do_reset();
      @(negedge sys_clk);
      rst = 1'b1;
      bus.req_valid = '0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst = 1'b0;
   endtask

   task automatic drive(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*BYTE_W-1:0] data);
      @(negedge sys_clk);
      bus.req_valid = mask;
      bus.req_data  = data;
      @(posedge sys_clk);
      #1;
      bus.req_valid = '0;
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_drain_timeout"}, 32'(n >= budget), 0);
   endtask

   task automatic wait_load(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!bus.tx_load && n < budget);
      check({tag, "_load_timeout"}, 32'(n >= budget), 0);
   endtask

   initial begin
      int base;
      int gap;
      int n;
      rst = 1'b0;
      en  = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;

      // Reset state, then single byte on req 0 with latency checks
      do_reset();
      check("reset_busy", 32'(busy), 0);
      check("reset_tx_load", 32'(bus.tx_load), 0);
      check("reset_grant_id", 32'(grant_id), 0);
      check("reset_tx_data", 32'(bus.tx_data), 0);
      check("reset_req_ready", 32'(bus.req_ready), 32'hF);
      check("reset_state", 32'(state_dbg), 0);
      exp_q.push_back({2'd0, 8'h41});
      drive(4'b0001, {24'h0, 8'h41});
      @(negedge sys_clk);
      check("t1_slot_full", 32'(bus.req_ready[0]), 0);
      check("t1_no_early_load", 32'(bus.tx_load), 0);
      @(negedge sys_clk);
      check("t1_load_latency", 32'(bus.tx_load), 1);
      check("t1_ready_after_grant", 32'(bus.req_ready[0]), 1);
      wait_drain(100, "t1");
      check("t1_load_count", load_cnt, 1);

      // All four slots in the same cycle, served in round-robin order
      do_reset();
      base = load_cnt;
      exp_q.push_back({2'd0, 8'h10});
      exp_q.push_back({2'd1, 8'h11});
      exp_q.push_back({2'd2, 8'h12});
      exp_q.push_back({2'd3, 8'h13});
      drive(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
      @(negedge sys_clk);
      check("t2_all_captured", 32'(bus.req_ready), 0);
      wait_drain(300, "t2");
      check("t2_load_count", load_cnt - base, 4);

      // Req 1 refills right after its grant while req 2 waits: 1,2,1
      do_reset();
      exp_q.push_back({2'd1, 8'hA1});
      exp_q.push_back({2'd2, 8'h22});
      exp_q.push_back({2'd1, 8'hA2});
      drive(4'b0110, {8'h00, 8'h22, 8'hA1, 8'h00});
      wait_load(20, "t3_first");
      drive(4'b0010, {16'h0, 8'hA2, 8'h00});
      wait_drain(300, "t3");

      // Transmitter never drops tx_load_okay: timeout path back to IDLE
      tx_stuck_idle = 1'b1;
      do_reset();
      exp_q.push_back({2'd0, 8'h55});
      exp_q.push_back({2'd1, 8'h66});
      drive(4'b0011, {16'h0, 8'h66, 8'h55});
      wait_load(20, "t4_first");
      gap = 0;
      do begin
         @(negedge sys_clk);
         gap++;
         if (gap == 10) check("t4_tx_data_held", 32'(bus.tx_data), 32'h55);
      end while (!bus.tx_load && gap < 100);
      check("t4_timeout_gap", gap, BUSY_TIMEOUT + 2);
      wait_drain(100, "t4");
      tx_stuck_idle = 1'b0;

      // Reset during WAIT_DONE with slots 2 and 3 holding bytes
      do_reset();
      exp_q.push_back({2'd0, 8'h50});
      drive(4'b0001, {24'h0, 8'h50});
      n = 0;
      while (state_dbg != 2'd3 && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      check("t5_reach_wait_done_timeout", 32'(n >= 20), 0);
      drive(4'b1100, {8'h33, 8'h32, 16'h0});
      @(negedge sys_clk);
      check("t5_slots_full", 32'(bus.req_ready), 32'h3);
      rst = 1'b1;
      @(negedge sys_clk);
      rst = 1'b0;
      check("t5_busy", 32'(busy), 0);
      check("t5_tx_load", 32'(bus.tx_load), 0);
      check("t5_req_ready", 32'(bus.req_ready), 32'hF);
      check("t5_state", 32'(state_dbg), 0);
      base = load_cnt;
      repeat (40) @(negedge sys_clk);
      check("t5_no_load_after_reset", load_cnt - base, 0);

      // en low holds the byte; raising en grants on the next edge
      do_reset();
      en = 1'b0;
      exp_q.push_back({2'd0, 8'h66});
      drive(4'b0001, {24'h0, 8'h66});
      base = load_cnt;
      repeat (100) @(negedge sys_clk);
      check("t6_no_load_while_disabled", load_cnt - base, 0);
      check("t6_byte_held", 32'(bus.req_ready[0]), 0);
      en = 1'b1;
      check("t6_no_load_yet", 32'(bus.tx_load), 0);
      @(negedge sys_clk);
      check("t6_load_after_en", 32'(bus.tx_load), 1);
      wait_drain(100, "t6");
      check("t6_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
